// File: rtl/simon_sequence_scheduler_if.sv
// Control, playback and pattern-read signals of the Simon sequence scheduler.
// master: game controller / input checker side (drives tick, new_game, seed, start, round, abort, rd_idx).
// slave : sequencer side (drives led_out, showing, busy, done, step_idx, rd_led).
interface simon_sequence_scheduler_if #(
   parameter int IDX_W = 3
);
   logic              tick;
   logic              new_game;
   logic [15:0]       seed;
   logic              start;
   logic [IDX_W-1:0]  round;
   logic              abort;
   logic [15:0]       led_out;
   logic              showing;
   logic              busy;
   logic              done;
   logic [IDX_W-1:0]  step_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic [3:0]        rd_led;

   modport master (
      output tick, new_game, seed, start, round, abort, rd_idx,
      input  led_out, showing, busy, done, step_idx, rd_led
   );

   modport slave (
      input  tick, new_game, seed, start, round, abort, rd_idx,
      output led_out, showing, busy, done, step_idx, rd_led
   );
endinterface

// File: rtl/simon_sequence_scheduler.sv
// Purpose: generate a per-game LFSR step list, then play steps 0..round onto 16 one-hot LEDs.
// Latency: FILL takes MAX_STEPS clks; first LED lights on the cycle after start; rd_led is combinational.
// Backpressure: none; start/new_game/tick are ignored while busy, abort always wins.
//
// Ports: clk, reset (async, active-low) plus interface bus (slave modport):
//   tick/new_game/seed/start/round/abort/rd_idx in; led_out/showing/busy/done/step_idx/rd_led out.
// Optional feature macro SIMON_SEQ_NOREPEAT_EN: prevents two consecutive stored steps from being equal.
module simon_sequence_scheduler #(
   parameter int MAX_STEPS     = 8,
   parameter int BASE_ON_TICKS = 8,
   parameter int MIN_ON_TICKS  = 2,
   parameter int OFF_TICKS     = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   simon_sequence_scheduler_if.slave bus
);
   localparam int IDX_W  = $clog2(MAX_STEPS);
   // Counter must hold any tick target and also any round value used in the on-time subtract.
   localparam int MAX_A  = (BASE_ON_TICKS > OFF_TICKS) ? BASE_ON_TICKS : OFF_TICKS;
   localparam int MAX_B  = (MAX_A > MIN_ON_TICKS) ? MAX_A : MIN_ON_TICKS;
   localparam int MAX_T  = (MAX_B > MAX_STEPS) ? MAX_B : MAX_STEPS;
   localparam int CNT_W  = $clog2(MAX_T + 1);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MAX_STEPS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] BASE_T    = CNT_W'(BASE_ON_TICKS);
   localparam logic [CNT_W-1:0] MIN_T     = CNT_W'(MIN_ON_TICKS);
   localparam logic [CNT_W-1:0] OFF_T     = CNT_W'(OFF_TICKS);
   localparam logic [15:0]      LFSR_INIT = 16'hACE1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_ON,
      S_OFF,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [15:0]      lfsr;
   logic [15:0]      lfsr_nxt;
   logic [3:0]       pattern [MAX_STEPS];
   logic [3:0]       fill_val;
   logic [IDX_W-1:0] fill_idx;
   logic [IDX_W-1:0] step_q;
   logic [IDX_W-1:0] round_l;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] on_ticks;
   logic [CNT_W-1:0] on_calc;
   logic [CNT_W-1:0] round_ext;
   logic             on_hit;
   logic             off_hit;

   // 16-bit Fibonacci LFSR, taps 16/14/13/11.
   assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

   always_comb begin
      fill_val = lfsr_nxt[3:0];
`ifdef SIMON_SEQ_NOREPEAT_EN
      // Flip bit 0 when the new step would repeat the previous one; LFSR itself is untouched.
      if ((fill_idx != '0) && (lfsr_nxt[3:0] == pattern[fill_idx - IDX_ONE])) begin
         fill_val = lfsr_nxt[3:0] ^ 4'h1;
      end
`endif
   end

   // on_ticks = max(BASE - round, MIN) with a saturating subtract. round is only IDX_W
   // bits wide, so it can never exceed MAX_STEPS-1 and needs no extra clamp.
   always_comb begin
      round_ext = CNT_W'(bus.round);
      if (round_ext < BASE_T) begin
         on_calc = BASE_T - round_ext;
      end else begin
         on_calc = '0;
      end
      if (on_calc < MIN_T) begin
         on_calc = MIN_T;
      end
   end

   // Ticks count in every cycle spent in ON/OFF; the tick that caused entry was
   // consumed by the previous state, so counting starts with the first cycle in the state.
   assign on_hit  = (state == S_ON)  && bus.tick && ((cnt + CNT_ONE) == on_ticks);
   assign off_hit = (state == S_OFF) && bus.tick && ((cnt + CNT_ONE) == OFF_T);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (bus.abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.new_game) begin
                  state_nxt = S_FILL;
               end else if (bus.start) begin
                  state_nxt = S_ON;
               end
            end
            S_FILL: begin
               if (fill_idx == LAST_IDX) begin
                  state_nxt = S_IDLE;
               end
            end
            S_ON: begin
               if (on_hit) begin
                  state_nxt = S_OFF;
               end
            end
            S_OFF: begin
               if (off_hit) begin
                  state_nxt = (step_q == round_l) ? S_DONE : S_ON;
               end
            end
            S_DONE: begin
               state_nxt = S_IDLE;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr     <= LFSR_INIT;
         fill_idx <= '0;
         step_q   <= '0;
         round_l  <= '0;
         on_ticks <= '0;
         cnt      <= '0;
         for (int i = 0; i < MAX_STEPS; i++) begin
            pattern[i] <= 4'h0;
         end
      end else begin
         // Tick counter restarts on every state change (ON->OFF, OFF->ON, abort, ...).
         if (state_nxt != state) begin
            cnt <= '0;
         end else if (((state == S_ON) || (state == S_OFF)) && bus.tick) begin
            cnt <= cnt + CNT_ONE;
         end

         if (!bus.abort) begin
            case (state)
               S_IDLE: begin
                  if (bus.new_game) begin
                     lfsr     <= (bus.seed == 16'h0000) ? LFSR_INIT : bus.seed;
                     fill_idx <= '0;
                  end else if (bus.start) begin
                     step_q   <= '0;
                     round_l  <= bus.round;
                     on_ticks <= on_calc;
                  end
               end
               S_FILL: begin
                  lfsr              <= lfsr_nxt;
                  pattern[fill_idx] <= fill_val;
                  fill_idx          <= fill_idx + IDX_ONE;
               end
               S_OFF: begin
                  if (state_nxt == S_ON) begin
                     step_q <= step_q + IDX_ONE;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // LED is decoded straight from state so reset darkens it without waiting for an edge.
   always_comb begin
      bus.led_out = '0;
      if (state == S_ON) begin
         bus.led_out[pattern[step_q]] = 1'b1;
      end
   end

   assign bus.showing  = (state == S_ON) || (state == S_OFF);
   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = (state == S_DONE);
   assign bus.step_idx = step_q;
   assign bus.rd_led   = pattern[bus.rd_idx];
endmodule

// File: tb/tb_simon_sequence_scheduler.sv
module tb_simon_sequence_scheduler;
   localparam int MAX_STEPS = 8;
   localparam int IDX_W     = 3;
   localparam int BASE_ON   = 8;
   localparam int MIN_ON    = 2;
   localparam int OFF_T     = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [3:0]  mdl_pat   [MAX_STEPS];
   logic [3:0]  seed1_exp [MAX_STEPS];
   logic [15:0] obs_led   [$];

   always #10 clk = ~clk;

   simon_sequence_scheduler_if #(.IDX_W(IDX_W)) bus ();

   simon_sequence_scheduler #(
      .MAX_STEPS    (MAX_STEPS),
      .BASE_ON_TICKS(BASE_ON),
      .MIN_ON_TICKS (MIN_ON),
      .OFF_TICKS    (OFF_T)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int k = 0; k < MAX_STEPS; k++) mdl_pat[k] = 4'h0;
   endtask

   // Pattern straight from the game rules: seed (0 -> ACE1), shift in the tap XOR, keep low nibble.
   task automatic model_fill(input logic [15:0] sd);
      logic [15:0] l;
      logic [3:0]  v;
      l = (sd == 16'h0) ? 16'hACE1 : sd;
      for (int k = 0; k < MAX_STEPS; k++) begin
         l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
         v = l[3:0];
`ifdef SIMON_SEQ_NOREPEAT_EN
         if (k > 0 && v == mdl_pat[k-1]) v = v ^ 4'h1;
`endif
         mdl_pat[k] = v;
      end
   endtask

   task automatic check_pattern(input string tag);
      for (int k = 0; k < MAX_STEPS; k++) begin
         bus.rd_idx = IDX_W'(k);
         #1;
         check(tag, 32'(bus.rd_led), 32'(mdl_pat[k]));
      end
   endtask

   task automatic do_fill(input logic [15:0] sd, input bit with_start, input string tag);
      int n;
      bus.seed     = sd;
      bus.new_game = 1'b1;
      bus.start    = with_start;
      bus.round    = IDX_W'($urandom);
      cyc();
      bus.new_game = 1'b0;
      bus.start    = 1'b0;
      if (with_start) begin
         check({tag, "_no_on"}, 32'(bus.showing), 32'(0));
         check({tag, "_led_dark"}, 32'(bus.led_out), 32'(0));
      end
      n = 0;
      while (bus.busy && n < 64) begin
         n++;
         cyc();
      end
      check({tag, "_busy_cycles"}, 32'(n), 32'(MAX_STEPS));
      model_fill(sd);
      check_pattern({tag, "_rd"});
   endtask

   // Expected trace built step by step: each step is lit until on_t ticks have been seen,
   // then dark until OFF_T ticks, then one DONE cycle.
   task automatic play(input int rnd, input int tick_pct, input bit noise, input string tag);
      bit          tv [1024];
      logic [15:0] exp_led [$];
      int          exp_step [$];
      logic [15:0] one;
      int          on_t, i, n, last;
      one  = 16'h1;
      on_t = BASE_ON - rnd;
      if (on_t < MIN_ON) on_t = MIN_ON;
      for (int k = 0; k < 1024; k++) tv[k] = (k >= 500) ? 1'b1 : ($urandom_range(99) < tick_pct);
      i = 0;
      for (int s = 0; s <= rnd; s++) begin
         n = 0;
         do begin
            exp_led.push_back(one << mdl_pat[s]);
            exp_step.push_back(s);
            if (tv[i]) n++;
            i++;
         end while (n < on_t);
         n = 0;
         do begin
            exp_led.push_back(16'h0);
            exp_step.push_back(s);
            if (tv[i]) n++;
            i++;
         end while (n < OFF_T);
      end
      exp_led.push_back(16'h0);
      exp_step.push_back(rnd);
      last = exp_led.size() - 1;
      obs_led.delete();

      bus.round = IDX_W'(rnd);
      bus.start = 1'b1;
      bus.tick  = 1'($urandom_range(1));
      cyc();
      bus.start = 1'b0;
      for (int c = 0; c <= last; c++) begin
         bus.tick = tv[c];
         if (noise) begin
            bus.start    = 1'($urandom_range(1));
            bus.new_game = 1'($urandom_range(1));
            bus.round    = IDX_W'($urandom);
            bus.seed     = 16'($urandom);
         end
         obs_led.push_back(bus.led_out);
         check({tag, "_led"}, 32'(bus.led_out), 32'(exp_led[c]));
         check({tag, "_step"}, 32'(bus.step_idx), 32'(exp_step[c]));
         check({tag, "_done"}, 32'(bus.done), 32'(c == last));
         check({tag, "_showing"}, 32'(bus.showing), 32'(c != last));
         cyc();
      end
      bus.start    = 1'b0;
      bus.new_game = 1'b0;
      bus.tick     = 1'b0;
      check({tag, "_busy_end"}, 32'(bus.busy), 32'(0));
      check({tag, "_done_end"}, 32'(bus.done), 32'(0));
      check({tag, "_step_hold"}, 32'(bus.step_idx), 32'(rnd));
   endtask

   initial begin
      int n;
`ifdef SIMON_SEQ_NOREPEAT_EN
      seed1_exp = '{4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
`else
      seed1_exp = '{4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`endif
      bus.tick     = 1'b0;
      bus.new_game = 1'b0;
      bus.seed     = 16'h0;
      bus.start    = 1'b0;
      bus.round    = '0;
      bus.abort    = 1'b0;
      bus.rd_idx   = '0;

      // Reset state
      #1;
      check("rst_led", 32'(bus.led_out), 32'(0));
      check("rst_busy", 32'(bus.busy), 32'(0));
      check("rst_showing", 32'(bus.showing), 32'(0));
      check("rst_done", 32'(bus.done), 32'(0));
      check("rst_step", 32'(bus.step_idx), 32'(0));
      model_reset();
      check_pattern("rst_rd");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      cyc();

      // Known-seed fill against hand-derived values
      do_fill(16'h0001, 1'b0, "seed1");
      for (int k = 0; k < MAX_STEPS; k++) begin
         bus.rd_idx = IDX_W'(k);
         #1;
         check("seed1_const", 32'(bus.rd_led), 32'(seed1_exp[k]));
      end

      // round=2, tick every cycle: 6 lit / 2 dark per step, three steps, then done
      play(2, 100, 1'b0, "r2");
      check("r2_len", 32'(obs_led.size()), 32'(25));
      check("r2_c0", 32'(obs_led[0]), 32'h0004);
      check("r2_c5", 32'(obs_led[5]), 32'h0004);
      check("r2_c6", 32'(obs_led[6]), 32'h0000);
      check("r2_c8", 32'(obs_led[8]), 32'h0010);
      check("r2_c16", 32'(obs_led[16]), 32'h0100);
      check("r2_c22", 32'(obs_led[22]), 32'h0000);

      // round=7: floor on-time, all 8 steps, irrelevant inputs toggled during playback
      play(7, 60, 1'b1, "r7");

      // Abort in the OFF gap of step 1, then replay with unchanged pattern
      bus.round = IDX_W'(3);
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      bus.tick  = 1'b1;
      n = 0;
      while (!(bus.showing && bus.led_out == 16'h0 && bus.step_idx == IDX_W'(1)) && n < 200) begin
         cyc();
         n++;
      end
      check("abort_reach_gap", 32'(n < 200), 32'(1));
      bus.abort = 1'b1;
      cyc();
      bus.abort = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'(0));
      check("abort_showing", 32'(bus.showing), 32'(0));
      check("abort_led", 32'(bus.led_out), 32'(0));
      for (int k = 0; k < 4; k++) begin
         check("abort_no_done", 32'(bus.done), 32'(0));
         cyc();
      end
      bus.tick = 1'b0;
      check_pattern("abort_rd");
      play(0, 100, 1'b0, "replay");

      // new_game + start together: FILL wins
      do_fill(16'($urandom), 1'b1, "ng_start");

      // Random games, including seed 0 which falls back to ACE1
      for (int g = 0; g < 5; g++) begin
         do_fill((g == 0) ? 16'h0 : 16'($urandom), 1'b0, "rnd_fill");
         play($urandom_range(MAX_STEPS - 1), $urandom_range(90, 30), 1'b1, "rnd_play");
      end

      // Reset asserted mid-ON: outputs fall without a clock edge, pattern cleared
      do_fill(16'h0001, 1'b0, "seed1b");
      bus.round = IDX_W'(2);
      bus.tick  = 1'b0;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      check("mid_on_led", 32'(bus.led_out), 32'h0004);
      #3;
      reset = 1'b0;
      #1;
      check("arst_led", 32'(bus.led_out), 32'(0));
      check("arst_busy", 32'(bus.busy), 32'(0));
      check("arst_showing", 32'(bus.showing), 32'(0));
      check("arst_step", 32'(bus.step_idx), 32'(0));
      model_reset();
      check_pattern("arst_rd");
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc();
      check("post_rst_busy", 32'(bus.busy), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/simon_sequence_scheduler.md
Name: simon_sequence_scheduler

Overview:
Sequencer for the Simon LED pattern. It generates and stores the per-game random step list, then plays the first round+1 steps onto the 16 LEDs with level-dependent on/off timing. It sits between game_controller (start/round/abort) and the LED mux, and it exposes a read port so the input checker can compare player entries against the stored pattern.

Parameters:
MAX_STEPS, 8, pattern depth; must be a power of 2; IDX_W = log2(MAX_STEPS).
BASE_ON_TICKS, 8, LED-on duration in ticks at round 0.
MIN_ON_TICKS, 2, floor for the LED-on duration.
OFF_TICKS, 2, dark gap in ticks after each step.

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle timing enable from clock_divider (e.g. 10 Hz strobe)
new_game  in  1  pulse: reseed and refill the pattern
seed  in  16  LFSR seed sampled on new_game
start  in  1  pulse: play steps 0..round
round  in  IDX_W  current round; plays round+1 steps
abort  in  1  pulse: stop immediately, return to IDLE
led_out  out  16  one-hot LED of the current step; 0 when dark
showing  out  1  high in ON/OFF states
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when playback completes
step_idx  out  IDX_W  index of the step being shown
rd_idx  in  IDX_W  checker read address
rd_led  out  4  pattern[rd_idx], combinational

Behaviour:
- Reset (reset=0, async): state=IDLE, lfsr=16'hACE1, all pattern entries=0, led_out=0, showing=0, busy=0, done=0, step_idx=0, tick counter=0.
- States: IDLE, FILL, ON, OFF, DONE.
- Priority each cycle: abort > new_game > start. abort in any state -> IDLE next cycle, led_out=0, pattern preserved.
- new_game is accepted only in IDLE. It loads lfsr=seed; seed=0 is replaced by 16'hACE1. It then enters FILL. start in the same cycle is ignored.
- FILL: runs one entry per clk, MAX_STEPS cycles, fill_idx 0..MAX_STEPS-1.
  - Each cycle: nxt = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}; lfsr<=nxt; pattern[fill_idx]<=nxt[3:0].
  - After the last entry -> IDLE. tick is ignored in FILL.
- start in IDLE (no new_game/abort) -> ON next cycle with step_idx=0. led_out = 1<<pattern[0] in the first ON cycle (1-cycle latency).
- round is sampled at start; values above MAX_STEPS-1 are clamped.
- on_ticks = max(BASE_ON_TICKS - round, MIN_ON_TICKS), computed at start. Use unsigned arithmetic with a saturating subtract.
- ON: the counter increments on tick. When the count reaches on_ticks -> OFF, counter cleared, led_out=0.
- OFF: when the count reaches OFF_TICKS:
  - if step_idx==round_latched -> DONE;
  - else step_idx++ -> ON.
- DONE: done=1 for exactly one cycle, led_out=0, then IDLE. step_idx holds its last value until the next start.
- start, new_game and tick are ignored while busy (except abort).
- A tick in the same cycle as the state entry does not count; counting begins on the cycle after entry.
- rd_led is always valid, including during playback. During FILL, rd_led returns the old or new entry depending on fill progress; the checker must not read during FILL.

Optional Feature:
SIMON_SEQ_NOREPEAT_EN
- Defined: during FILL, for fill_idx>0, if nxt[3:0] equals the stored pattern[fill_idx-1], store nxt[3:0]^4'h1 instead. No two consecutive steps then light the same LED. The LFSR sequence itself is unchanged.
- Undefined: raw nxt[3:0] is stored; repeats are allowed.

Test Plan:
- Reset mid-ON (reset=0 for 1 cycle with led_out=16'h0004) -> led_out=0, busy=0, state IDLE immediately, without waiting for a clk edge.
- new_game with seed=16'h0001, then read rd_idx 0..7 after busy falls:
  - feature off -> 2,4,8,0,0,0,0,0;
  - feature on -> 2,4,8,0,1,0,1,0.
  - busy must be high for exactly 8 cycles.
- After the seed=1 fill, start with round=2 and tick every cycle:
  - led_out = 16'h0004 for 6 ticks, then 0 for 2, then 16'h0010 for 6, 0 for 2, 16'h0100 for 6, 0 for 2;
  - then done pulses once and busy falls.
- round=7 -> on_ticks=2 (saturated floor, BASE 8-7=1 <2); 8 steps shown; step_idx reaches 7 before done.
- abort asserted during the OFF gap of step 1 -> IDLE next cycle, done never asserted; a subsequent start replays from step 0 with the unchanged pattern.
- Simultaneous new_game+start in IDLE -> FILL taken, no ON; start issued during ON is ignored (step timing unchanged).
